// File: rtl/seq_detector_prog_if.sv
// Serial-stream, configuration and status signals of the programmable pattern detector.
// master = stream/config source, slave = detector.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 16
);
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_cnt;
    logic               z;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_cnt,
        input  z, cfg_err, match_cnt
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_cnt,
        output z, cfg_err, match_cnt
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: Mealy z (0-cycle latency), 1-cycle cfg_err pulse.
// Saturating match counter present only when SEQ_DET_MATCH_CNT_EN is defined; otherwise match_cnt is 0.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    seq_detector_prog_if.slave bus
);
    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_err;

    logic [MAX_LEN-1:0] w_shift;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_inc;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic               w_take;
    logic               w_cfg_ok;
    logic               w_match;

    assign w_take  = bus.x_valid && !bus.cfg_load;
    assign w_shift = {r_hist[MAX_LEN-2:0], bus.x};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    // One extra bit so fill+1 cannot wrap when MAX_LEN == 2**LEN_W-1.
    assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_fill_nxt = (w_fill_inc >= (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                            : w_fill_inc[LEN_W-1:0];
    assign w_match    = w_take && (w_fill_inc >= {1'b0, r_len})
                        && (((w_shift ^ r_pat) & w_mask) == '0);
    assign w_cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

    assign bus.z       = w_match && !i_rst;
    assign bus.cfg_err = r_cfg_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= '0;
            r_len     <= LEN_W'(1);
            r_overlap <= 1'b1;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_load && !w_cfg_ok;
            if (bus.cfg_load) begin
                if (w_cfg_ok) begin
                    r_pat     <= bus.cfg_pattern;
                    r_len     <= bus.cfg_len;
                    r_overlap <= bus.cfg_overlap;
                    r_hist    <= '0;
                    r_fill    <= '0;
                end
            end else if (bus.x_valid) begin
                r_hist <= w_shift;
                r_fill <= (w_match && !r_overlap) ? '0 : w_fill_nxt;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = r_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr  = bus.clr_cnt;
    assign bus.match_cnt = '0;
`endif
endmodule
